// File: rtl/stage_clock_gen.sv
// stage_clock_gen: reset sequencer plus NUM_CH programmable clock-enable
// strobes and a free-running active-cycle counter, all on one clock.
`timescale 1ns/1ps

module stage_clock_gen #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    cfg_load,
   input  logic [NUM_CH*DIV_W-1:0] cfg_div,
   input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
   output logic                    sys_reset,
   output logic                    ready,
   output logic [NUM_CH-1:0]       ch_en,
   output logic [31:0]             cycle_count
);

   localparam logic [7:0]       HOLD  = 8'(HOLD_CYCLES);
   localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

   logic [1:0]       sync_q;
   logic [7:0]       hold_q;
   logic [31:0]      cycle_q;
   logic [DIV_W-1:0] div_q     [NUM_CH];
   logic [DIV_W-1:0] phase_q   [NUM_CH];
   logic [DIV_W-1:0] cnt_q     [NUM_CH];
   logic [DIV_W-1:0] div_eff   [NUM_CH];
   logic [DIV_W-1:0] phase_eff [NUM_CH];
   logic [NUM_CH-1:0] wrap;
   logic             active;

   // Two-flop synchroniser for the release edge of the external reset.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others (the shift needs this).
      if (!reset) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], 1'b1};
   end

   // Stretch the synchronised release by HOLD_CYCLES edges.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                          hold_q <= '0;
      else if (sync_q[1] && hold_q != HOLD) hold_q <= hold_q + 8'd1;
   end

   assign sys_reset = !(sync_q[1] && (hold_q == HOLD));
   assign ready     = !sys_reset;
   assign active    = ready && run;

   // Effective divide/phase, wrap detect and strobe decode per channel.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the loop can leave a value unassigned and infer a latch.
      ch_en = '0;
      wrap  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         div_eff[i]   = (div_q[i] == '0) ? ONE_D : div_q[i];
         phase_eff[i] = (phase_q[i] >= div_eff[i]) ? (div_eff[i] - ONE_D) : phase_q[i];
         wrap[i]      = (cnt_q[i] >= (div_eff[i] - ONE_D));
         ch_en[i]     = active && (cnt_q[i] == phase_eff[i]);
      end
   end

   // Config registers and channel counters; cfg_load realigns every channel.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: the config array is reset on purpose: a reset must return every
      // channel to div=1/phase=0, so it cannot be left as uninitialised storage.
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= ONE_D;
            phase_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
      end else if (cfg_load) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= cfg_div[i*DIV_W +: DIV_W];
            phase_q[i] <= cfg_phase[i*DIV_W +: DIV_W];
            cnt_q[i]   <= '0;
         end
      end else if (active) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= wrap[i] ? '0 : (cnt_q[i] + ONE_D);
         end
      end
   end

   // Free-running count of active cycles; wraps naturally at 32 bits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      cycle_q <= '0;
      else if (active) cycle_q <= cycle_q + 32'd1;
   end

   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_stage_clock_gen.sv
// Directed testbench for stage_clock_gen: reset sequencing, strobe schedules,
// clamping, freeze, realignment, async reset and cycle counter wrap.
`timescale 1ns/1ps

module tb_stage_clock_gen;

   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 4;
   localparam int HOLD_CYCLES = 2;

   logic                    clock = 1'b0;
   logic                    reset = 1'b0;
   logic                    run = 1'b0;
   logic                    cfg_load = 1'b0;
   logic [NUM_CH*DIV_W-1:0] cfg_div = '0;
   logic [NUM_CH*DIV_W-1:0] cfg_phase = '0;
   logic                    sys_reset;
   logic                    ready;
   logic [NUM_CH-1:0]       ch_en;
   logic [31:0]             cycle_count;

   int n_cmp = 0;
   int n_bad = 0;

   // div={4,3,2,1}, phase={3,1,0,0} for ch3..ch0, active cycles k=0..11
   logic [3:0] exp_a [12] = '{4'b0011, 4'b0101, 4'b0011, 4'b1001,
                              4'b0111, 4'b0001, 4'b0011, 4'b1101,
                              4'b0011, 4'b0001, 4'b0111, 4'b1001};
   // div={5,3,2,0}, phase={2,7,7,5}: effective phases {2,2,1,0}, k=0..9
   logic [3:0] exp_b [10] = '{4'b0001, 4'b0011, 4'b1101, 4'b0011, 4'b0001,
                              4'b0111, 4'b0001, 4'b1011, 4'b0101, 4'b0011};

   stage_clock_gen #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .HOLD_CYCLES(HOLD_CYCLES)
   ) dut (
      .clock(clock), .reset(reset), .run(run), .cfg_load(cfg_load),
      .cfg_div(cfg_div), .cfg_phase(cfg_phase), .sys_reset(sys_reset),
      .ready(ready), .ch_en(ch_en), .cycle_count(cycle_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      // Reset held low for three cycles
      run = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("rst_sys_reset", 32'(sys_reset), 32'd1);
         check("rst_ready", 32'(ready), 32'd0);
         check("rst_ch_en", 32'(ch_en), 32'd0);
         check("rst_cycle_count", cycle_count, 32'd0);
      end
      reset = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clock);
         check($sformatf("release_edge%0d", e), 32'(sys_reset), (e < 4) ? 32'd1 : 32'd0);
      end
      check("release_ready", 32'(ready), 32'd1);
      check("release_count", cycle_count, 32'd0);

      // Default strobes: all channels always on
      for (int c = 0; c < 10; c++) begin
         check("default_ch_en", 32'(ch_en), 32'hF);
         @(negedge clock);
      end
      check("default_count10", cycle_count, 32'd10);

      // Divide and phase schedule with a freeze in the middle
      cfg_div   = {4'd4, 4'd3, 4'd2, 4'd1};
      cfg_phase = {4'd3, 4'd1, 4'd0, 4'd0};
      cfg_load  = 1'b1;
      @(negedge clock);
      cfg_load = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (k == 6) begin
            run = 1'b0;
            #1 check("freeze_gate", 32'(ch_en), 32'd0);
            repeat (5) begin
               @(negedge clock);
               #1;
               check("freeze_ch_en", 32'(ch_en), 32'd0);
               check("freeze_count", cycle_count, 32'd17);
            end
            run = 1'b1;
         end
         #1 check($sformatf("sched_a_k%0d", k), 32'(ch_en), 32'(exp_a[k]));
         if (k == 11) begin
            check("sched_a_count", cycle_count, 32'd22);
            // Reload on the edge where ch1..ch3 wrap; exercises div=0 and clamped phases
            cfg_div   = {4'd5, 4'd3, 4'd2, 4'd0};
            cfg_phase = {4'd2, 4'd7, 4'd7, 4'd5};
            cfg_load  = 1'b1;
         end
         @(negedge clock);
      end
      cfg_load = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1 check($sformatf("sched_b_k%0d", k), 32'(ch_en), 32'(exp_b[k]));
         if (k == 9) check("sched_b_count", cycle_count, 32'd32);
         @(negedge clock);
      end

      // Asynchronous reset between edges
      #2 reset = 1'b0;
      #1;
      check("async_sys_reset", 32'(sys_reset), 32'd1);
      check("async_ready", 32'(ready), 32'd0);
      check("async_ch_en", 32'(ch_en), 32'd0);
      check("async_count", cycle_count, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clock);
         check($sformatf("rerelease_edge%0d", e), 32'(sys_reset), (e < 4) ? 32'd1 : 32'd0);
      end
      check("cfg_cleared_ch_en", 32'(ch_en), 32'hF);
      check("rerelease_count", cycle_count, 32'd0);

      // cfg_load during the hold window is kept through release
      #2 reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      cfg_div   = {4'd1, 4'd1, 4'd1, 4'd2};
      cfg_phase = {4'd0, 4'd0, 4'd0, 4'd1};
      cfg_load  = 1'b1;
      @(negedge clock);
      cfg_load = 1'b0;
      check("hold_load_sys_reset", 32'(sys_reset), 32'd1);
      repeat (2) @(negedge clock);
      check("hold_load_ready", 32'(ready), 32'd1);
      check("hold_load_k0", 32'(ch_en), 32'hE);
      @(negedge clock);
      check("hold_load_k1", 32'(ch_en), 32'hF);
      @(negedge clock);
      check("hold_load_k2", 32'(ch_en), 32'hE);

      // Cycle counter wrap from a preset value
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1 release dut.cycle_q;
      #1 check("wrap_preset", cycle_count, 32'hFFFF_FFFE);
      @(negedge clock);
      check("wrap_max", cycle_count, 32'hFFFF_FFFF);
      @(negedge clock);
      check("wrap_zero", cycle_count, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
